// File: rtl/gcd_engine.sv
// Subtractive GCD engine: a single controller plus datapath with a start/busy/done handshake.
// Each clock in RUN performs one subtraction. The iteration count saturates instead of wrapping.
module gcd_engine #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd_out,
    output logic             zero_err,
    output logic [CNT_W-1:0] iter
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   gcd_q, gcd_d;
    logic [CNT_W-1:0]   iter_q, iter_d;
    logic               zero_err_q, zero_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            gcd_q      <= '0;
            iter_q     <= '0;
            zero_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            gcd_q      <= gcd_d;
            iter_q     <= iter_d;
            zero_err_q <= zero_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        gcd_d      = gcd_q;
        iter_d     = iter_q;
        zero_err_d = zero_err_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d        = a_in;
                    b_d        = b_in;
                    iter_d     = '0;
                    zero_err_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (a_q == '0 && b_q == '0) begin
                    gcd_d      = '0;
                    zero_err_d = 1'b1;
                    state_d    = DONE;
                end else if (a_q == '0) begin
                    gcd_d   = b_q;
                    state_d = DONE;
                end else if (b_q == '0 || a_q == b_q) begin
                    gcd_d   = a_q;
                    state_d = DONE;
                end else begin
                    // The larger operand is always the minuend, so no borrow is possible.
                    if (a_q > b_q) a_d = a_q - b_q;
                    else           b_d = b_q - a_q;
                    if (iter_q != {CNT_W{1'b1}}) iter_d = iter_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign gcd_out  = gcd_q;
    assign zero_err = zero_err_q;
    assign iter     = iter_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Bench for gcd_engine: three instances (16/16, 8/4, 4/4) share stimulus; a selector picks which one is checked.
module tb_gcd_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a, b;
    int          sel;

    logic        busy16, done16, zerr16;
    logic [15:0] gcd16, iter16;
    logic        busy8, done8, zerr8;
    logic [7:0]  gcd8;
    logic [3:0]  iter8;
    logic        busy4, done4, zerr4;
    logic [3:0]  gcd4, iter4;

    logic        busy_s, done_s, zerr_s;
    logic [15:0] gcd_s, iter_s;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [15:0] gcd;
        logic [15:0] iter;
        logic        zerr;
        int          lat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] gcd;
        logic [15:0] iter;
        logic        zerr;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    gcd_engine #(.WIDTH(16), .CNT_W(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a), .b_in(b),
        .busy(busy16), .done(done16), .gcd_out(gcd16), .zero_err(zerr16), .iter(iter16));

    gcd_engine #(.WIDTH(8), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a[7:0]), .b_in(b[7:0]),
        .busy(busy8), .done(done8), .gcd_out(gcd8), .zero_err(zerr8), .iter(iter8));

    gcd_engine #(.WIDTH(4), .CNT_W(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a[3:0]), .b_in(b[3:0]),
        .busy(busy4), .done(done4), .gcd_out(gcd4), .zero_err(zerr4), .iter(iter4));

    always_comb begin
        busy_s = busy16; done_s = done16; zerr_s = zerr16; gcd_s = gcd16; iter_s = iter16;
        case (sel)
            1: begin
                busy_s = busy8; done_s = done8; zerr_s = zerr8;
                gcd_s = {8'h00, gcd8}; iter_s = {12'h000, iter8};
            end
            2: begin
                busy_s = busy4; done_s = done4; zerr_s = zerr4;
                gcd_s = {12'h000, gcd4}; iter_s = {12'h000, iter4};
            end
            default: ;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_err++;
        $display("FAIL %s: timed out waiting for the DUT", nm);
    endtask

    // Reference gcd via modulo Euclid; subtraction count is the sum of the quotients minus one.
    task automatic model(input int x0, input int y0, output exp_t e);
        int x, y, t, k;
        x = x0; y = y0; k = 0;
        if (x != 0 && y != 0) begin
            if (x < y) begin t = x; x = y; y = t; end
            while (y != 0) begin
                k += x / y;
                t = x % y; x = y; y = t;
            end
            k = k - 1;
        end else begin
            x = x0 + y0;
        end
        e.gcd  = 16'(x);
        e.iter = 16'((k > 15) ? 15 : k);
        e.zerr = (x0 == 0 && y0 == 0);
        e.lat  = k + 2;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy16 || busy8 || busy4) && t < 2000) begin
            @(posedge clk); #1; t++;
        end
        if (busy16 || busy8 || busy4) timeout("wait_idle");
    endtask

    // Accept edge is counted as edge 1; returns the edge on which done rose.
    task automatic run_job(input logic [15:0] av, input logic [15:0] bv,
                           output int lat, output int busy_cnt);
        wait_idle();
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        busy_cnt = busy_s ? 1 : 0;
        while (!done_s && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
            if (busy_s) busy_cnt++;
        end
        if (!done_s) timeout("run_job");
    endtask

    task automatic check_job(input string nm, input int lat);
        exp_t e;
        if (sb.size() == 0) begin
            timeout({nm, "_scoreboard_empty"});
        end else begin
            e = sb.pop_front();
            chk({nm, "_gcd"},  gcd_s,  e.gcd);
            chk({nm, "_iter"}, iter_s, e.iter);
            chk({nm, "_zerr"}, zerr_s, e.zerr);
            chk({nm, "_lat"},  lat,    e.lat);
        end
    endtask

    initial begin
        int   lat, bc, n;
        exp_t e;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sel = 0;
        #12;
        chk("rst_busy", busy16, 0);
        chk("rst_done", done16, 0);
        chk("rst_gcd",  gcd16,  0);
        chk("rst_zerr", zerr16, 0);
        chk("rst_iter", iter16, 0);
        chk("rst_sat_iter", iter8, 0);
        @(negedge clk) rst_n = 1'b1;

        vecs[0] = '{16'd48,  16'd18, 16'd6,  16'd4, 1'b0};
        vecs[1] = '{16'd0,   16'd7,  16'd7,  16'd0, 1'b0};
        vecs[2] = '{16'd0,   16'd0,  16'd0,  16'd0, 1'b1};
        vecs[3] = '{16'd9,   16'd0,  16'd9,  16'd0, 1'b0};
        vecs[4] = '{16'd35,  16'd21, 16'd7,  16'd3, 1'b0};
        vecs[5] = '{16'd12,  16'd8,  16'd4,  16'd2, 1'b0};
        vecs[6] = '{16'd100, 16'd75, 16'd25, 16'd3, 1'b0};
        vecs[7] = '{16'd17,  16'd17, 16'd17, 16'd0, 1'b0};

        sel = 0;
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{vecs[i].gcd, vecs[i].iter, vecs[i].zerr, int'(vecs[i].iter) + 2});
            run_job(vecs[i].a, vecs[i].b, lat, bc);
            check_job("vec", lat);
            chk("vec_busy_cycles", bc, lat - 1);
            chk("vec_busy_at_done", busy_s, 0);
        end

        // Saturation: 19 subtractions into a 4-bit counter.
        sel = 1;
        sb.push_back('{16'd1, 16'd15, 1'b0, 21});
        run_job(16'd1, 16'd20, lat, bc);
        check_job("sat", lat);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_iter_held", iter8, 15);
        chk("sat_done_held", done8, 1);

        // Back-to-back: start held in DONE launches the next job with no idle cycle.
        sel = 0;
        sb.push_back('{16'd7, 16'd3, 1'b0, 5});
        run_job(16'd35, 16'd21, lat, bc);
        check_job("b2b_first", lat);
        @(negedge clk);
        a = 16'd17; b = 16'd17; start = 1'b1;
        @(posedge clk); #1;
        chk("b2b_done_drop", done16, 0);
        chk("b2b_busy_rise", busy16, 1);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_done", done16, 1);
        chk("b2b_gcd",  gcd16, 17);
        chk("b2b_iter", iter16, 0);

        // A start pulse during RUN with different operands must be ignored.
        wait_idle();
        @(negedge clk);
        a = 16'd48; b = 16'd18; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        a = 16'd1; b = 16'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 2;
        while (!done16 && lat < 2000) begin @(posedge clk); #1; lat++; end
        if (!done16) timeout("run_start");
        chk("run_start_gcd",  gcd16, 6);
        chk("run_start_iter", iter16, 4);
        chk("run_start_lat",  lat, 6);

        // Asynchronous reset mid-job, then release with start already high.
        wait_idle();
        @(negedge clk);
        a = 16'd1; b = 16'hFFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        chk("midrun_iter", iter16, 99);
        chk("midrun_busy", busy16, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy16, 0);
        chk("arst_done", done16, 0);
        chk("arst_gcd",  gcd16, 0);
        chk("arst_iter", iter16, 0);
        chk("arst_zerr", zerr16, 0);
        a = 16'd12; b = 16'd8; start = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("post_rst_accept", busy16, 1);
        lat = 1;
        while (!done16 && lat < 2000) begin @(posedge clk); #1; lat++; end
        if (!done16) timeout("post_rst");
        chk("post_rst_gcd",  gcd16, 4);
        chk("post_rst_iter", iter16, 2);
        chk("post_rst_lat",  lat, 4);

        // Exhaustive 4-bit sweep against the reference model.
        sel = 2;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                model(i, j, e);
                sb.push_back(e);
                run_job(16'(i), 16'(j), lat, bc);
                check_job("exh", lat);
                n++;
            end
        end
        chk("exh_count", n, 256);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
